// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - field-input and word-output handshake bundle for instr_encoder
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_kind;
    logic [3:0]  in_alu_op;
    logic [2:0]  in_mem_f3;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;

    // Environment side: produces fields, consumes words
    modport master (
        output in_valid, in_kind, in_alu_op, in_mem_f3, in_rd, in_rs1, in_rs2, in_imm,
        output out_ready,
        input  in_ready, out_valid, out_instr, out_err
    );

    // Encoder side
    modport slave (
        input  in_valid, in_kind, in_alu_op, in_mem_f3, in_rd, in_rs1, in_rs2, in_imm,
        input  out_ready,
        output in_ready, out_valid, out_instr, out_err
    );
endinterface

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - streaming RV32I instruction encoder, 2-stage valid/ready pipeline
module instr_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    instr_encoder_if.slave   bus,
    output logic             err_sticky,
    output logic [CNT_W-1:0] emit_cnt,
    output logic [CNT_W-1:0] err_cnt
);
    localparam logic [6:0]  OP_LUI    = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_IMM    = 7'b0010011;
    localparam logic [6:0]  OP_REG    = 7'b0110011;
    localparam logic [31:0] NOP_WORD  = 32'h00000013;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic        s1_valid;
    logic [3:0]  s1_kind;
    logic [3:0]  s1_alu_op;
    logic [2:0]  s1_f3;
    logic [4:0]  s1_rd;
    logic [4:0]  s1_rs1;
    logic [4:0]  s1_rs2;
    logic [31:0] s1_imm;

    logic        adv1;
    logic        adv2;
    logic        fire_out;
    logic        fits12;
    logic        fits13;
    logic        fits21;
    logic        is_shift;
    logic [6:0]  funct7;
    logic [2:0]  alu_f3;
    logic [2:0]  br_f3;
    logic [31:0] word;
    logic        legal;
    logic [31:0] enc_word;
    logic        enc_err;

    // Output stage moves when empty or drained; S1 moves when empty or S2 moves
    assign adv2         = !bus.out_valid || bus.out_ready;
    assign adv1         = !s1_valid || adv2;
    assign bus.in_ready = adv1;
    assign fire_out     = bus.out_valid && bus.out_ready;

    // Immediate range checks: upper bits must all replicate the sign bit
    assign fits12   = (s1_imm[31:11] == '0) || (s1_imm[31:11] == '1);
    assign fits13   = (s1_imm[31:12] == '0) || (s1_imm[31:12] == '1);
    assign fits21   = (s1_imm[31:20] == '0) || (s1_imm[31:20] == '1);
    assign is_shift = (s1_alu_op == 4'd2) || (s1_alu_op == 4'd6) || (s1_alu_op == 4'd7);
    assign funct7   = ((s1_alu_op == 4'd1) || (s1_alu_op == 4'd7)) ? 7'b0100000 : 7'b0000000;

    // Stage 1: capture raw fields when the pipeline can advance
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (adv1) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_kind   <= bus.in_kind;
                s1_alu_op <= bus.in_alu_op;
                s1_f3     <= bus.in_mem_f3;
                s1_rd     <= bus.in_rd;
                s1_rs1    <= bus.in_rs1;
                s1_rs2    <= bus.in_rs2;
                s1_imm    <= bus.in_imm;
            end
        end
    end

    // ALU and branch operation numbering to funct3
    always_comb begin
        alu_f3 = 3'b000;
        br_f3  = 3'b000;
        case (s1_alu_op)
            4'd2:    alu_f3 = 3'b001;
            4'd3:    alu_f3 = 3'b010;
            4'd4:    alu_f3 = 3'b011;
            4'd5:    alu_f3 = 3'b100;
            4'd6,
            4'd7:    alu_f3 = 3'b101;
            4'd8:    alu_f3 = 3'b110;
            4'd9:    alu_f3 = 3'b111;
            4'd11:   br_f3  = 3'b001;
            4'd12:   br_f3  = 3'b100;
            4'd13:   br_f3  = 3'b101;
            4'd14:   br_f3  = 3'b110;
            4'd15:   br_f3  = 3'b111;
            default: alu_f3 = 3'b000;
        endcase
    end

    // Assemble the word for the requested format and decide legality
    always_comb begin
        word  = NOP_WORD;
        legal = 1'b0;
        case (s1_kind)
            4'd0, 4'd1: begin
                word  = {s1_imm[31:12], s1_rd, (s1_kind == 4'd0) ? OP_LUI : OP_AUIPC};
                legal = (s1_imm[11:0] == 12'h000);
            end
            4'd2: begin
                word  = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, OP_JAL};
                legal = fits21 && !s1_imm[0];
            end
            4'd3: begin
                word  = {s1_imm[11:0], s1_rs1, 3'b000, s1_rd, OP_JALR};
                legal = fits12;
            end
            4'd4: begin
                word  = {s1_imm[11:0], s1_rs1, s1_f3, s1_rd, OP_LOAD};
                legal = fits12 && (s1_f3 != 3'b011) && (s1_f3 != 3'b110) && (s1_f3 != 3'b111);
            end
            4'd5: begin
                word  = {s1_imm[11:5], s1_rs2, s1_rs1, s1_f3, s1_imm[4:0], OP_STORE};
                legal = fits12 && (s1_f3 < 3'b011);
            end
            4'd6: begin
                word  = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, br_f3,
                         s1_imm[4:1], s1_imm[11], OP_BRANCH};
                legal = fits13 && !s1_imm[0] && (s1_alu_op >= 4'd10);
            end
            4'd7: begin
                if (is_shift) begin
                    word  = {funct7, s1_imm[4:0], s1_rs1, alu_f3, s1_rd, OP_IMM};
                    legal = (s1_imm[31:5] == '0);
                end else begin
                    word  = {s1_imm[11:0], s1_rs1, alu_f3, s1_rd, OP_IMM};
                    legal = fits12 && (s1_alu_op != 4'd1) && (s1_alu_op < 4'd10);
                end
            end
            4'd8: begin
                word  = {funct7, s1_rs2, s1_rs1, alu_f3, s1_rd, OP_REG};
                legal = (s1_alu_op < 4'd10);
            end
            default: begin
                word  = NOP_WORD;
                legal = 1'b0;
            end
        endcase
        enc_err  = !legal;
        enc_word = legal ? word : NOP_WORD;
    end

    // Stage 2: output register, held while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_instr <= 32'h0;
            bus.out_err   <= 1'b0;
        end else if (adv2) begin
            bus.out_valid <= s1_valid;
            if (s1_valid) begin
                bus.out_instr <= enc_word;
                bus.out_err   <= enc_err;
            end
        end
    end

    // Status: sticky error as soon as an error word is presented, handshake counters
    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky <= 1'b0;
            emit_cnt   <= '0;
            err_cnt    <= '0;
        end else begin
            if (adv2 && s1_valid && enc_err) begin
                err_sticky <= 1'b1;
            end
            if (fire_out) begin
                emit_cnt <= emit_cnt + CNT_ONE;
                if (bus.out_err) begin
                    err_cnt <= err_cnt + CNT_ONE;
                end
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - self-checking bench for instr_encoder
module tb_instr_encoder;
    logic        clk = 1'b0;
    logic        rst;
    logic        err_sticky;
    logic [15:0] emit_cnt;
    logic [15:0] err_cnt;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    instr_encoder_if bus ();

    instr_encoder #(.CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .err_sticky (err_sticky),
        .emit_cnt   (emit_cnt),
        .err_cnt    (err_cnt)
    );

    typedef struct {
        logic [3:0]  kind;
        logic [3:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } fields_t;

    typedef struct {
        logic [31:0] word;
        logic        err;
    } exp_t;

    int alu_f3_tab [10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
    int br_f3_tab  [6]  = '{0, 1, 4, 5, 6, 7};
    int load_f3_ok [5]  = '{0, 1, 2, 4, 5};

    function automatic bit fits(int s, int n);
        return (s >= -(1 << (n - 1))) && (s < (1 << (n - 1)));
    endfunction

    function automatic logic [31:0] sext(logic [31:0] v, int n);
        int x;
        x = int'(v) & ((1 << n) - 1);
        if (x >= (1 << (n - 1))) x = x - (1 << n);
        return x;
    endfunction

    // Reference: what an assembler would emit for these fields, or a flagged NOP
    function automatic exp_t model(fields_t f);
        exp_t        e;
        int          s;
        int          opi;
        bit          ok;
        logic [31:0] w;
        logic [2:0]  f3;
        logic [6:0]  f7;
        s   = f.imm;
        opi = f.op;
        ok  = 1'b1;
        w   = 32'h0;
        f7  = (opi == 1 || opi == 7) ? 7'h20 : 7'h00;
        f3  = (opi < 10) ? 3'(alu_f3_tab[opi % 10]) : 3'(br_f3_tab[(opi - 10) % 6]);
        case (int'(f.kind))
            0, 1: begin
                ok = (f.imm % 4096) == 0;
                w  = {f.imm[31:12], f.rd, (f.kind == 0) ? 7'h37 : 7'h17};
            end
            2: begin
                ok = fits(s, 21) && (f.imm % 2 == 0);
                w  = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, 7'h6F};
            end
            3: begin
                ok = fits(s, 12);
                w  = {f.imm[11:0], f.rs1, 3'b000, f.rd, 7'h67};
            end
            4: begin
                ok = fits(s, 12) && (f.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
                w  = {f.imm[11:0], f.rs1, f.f3, f.rd, 7'h03};
            end
            5: begin
                ok = fits(s, 12) && (f.f3 < 3);
                w  = {f.imm[11:5], f.rs2, f.rs1, f.f3, f.imm[4:0], 7'h23};
            end
            6: begin
                ok = (opi >= 10) && fits(s, 13) && (f.imm % 2 == 0);
                w  = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f3, f.imm[4:1], f.imm[11], 7'h63};
            end
            7: begin
                if (opi == 1 || opi >= 10) begin
                    ok = 1'b0;
                end else if (opi == 2 || opi == 6 || opi == 7) begin
                    ok = f.imm < 32;
                    w  = {f7, f.imm[4:0], f.rs1, f3, f.rd, 7'h13};
                end else begin
                    ok = fits(s, 12);
                    w  = {f.imm[11:0], f.rs1, f3, f.rd, 7'h13};
                end
            end
            8: begin
                ok = opi < 10;
                w  = {f7, f.rs2, f.rs1, f3, f.rd, 7'h33};
            end
            default: ok = 1'b0;
        endcase
        e.err  = !ok;
        e.word = ok ? w : 32'h00000013;
        return e;
    endfunction

    function automatic fields_t rand_legal();
        fields_t f;
        int      op;
        f.kind = 4'($urandom_range(0, 8));
        f.op   = 4'($urandom_range(0, 15));
        f.f3   = 3'($urandom_range(0, 7));
        f.rd   = 5'($urandom);
        f.rs1  = 5'($urandom);
        f.rs2  = 5'($urandom);
        f.imm  = sext($urandom, 12);
        case (int'(f.kind))
            0, 1: f.imm = $urandom & 32'hFFFFF000;
            2:    f.imm = sext($urandom & 32'h001FFFFE, 21);
            4:    f.f3  = 3'(load_f3_ok[$urandom_range(0, 4)]);
            5:    f.f3  = 3'($urandom_range(0, 2));
            6: begin
                f.op  = 4'($urandom_range(10, 15));
                f.imm = sext($urandom & 32'h00001FFE, 13);
            end
            7: begin
                op = $urandom_range(0, 8);
                if (op >= 1) op = op + 1;
                f.op = 4'(op);
                if (op == 2 || op == 6 || op == 7) f.imm = $urandom_range(0, 31);
            end
            8:       f.op = 4'($urandom_range(0, 9));
            default: f.op = f.op;
        endcase
        return f;
    endfunction

    function automatic fields_t rand_illegal();
        fields_t f;
        f = rand_legal();
        case ($urandom_range(0, 10))
            0:  f.kind = 4'($urandom_range(9, 15));
            1:  begin f.kind = 4'd8; f.op = 4'($urandom_range(10, 15)); end
            2:  begin f.kind = 4'd7; f.op = 4'd1; f.imm = 32'd4; end
            3:  begin f.kind = 4'd6; f.op = 4'($urandom_range(0, 9)); f.imm = 32'd16; end
            4:  begin f.kind = 4'd4; f.f3 = 3'(($urandom_range(0, 2) == 0) ? 3 : $urandom_range(6, 7)); end
            5:  begin f.kind = 4'd5; f.f3 = 3'($urandom_range(3, 7)); end
            6:  begin f.kind = 4'd0; f.imm = ($urandom & 32'hFFFFF000) | $urandom_range(1, 4095); end
            7:  begin f.kind = 4'd2; f.imm = sext($urandom & 32'h001FFFFE, 21) | 32'd1; end
            8:  begin f.kind = 4'd3; f.imm = 32'd2048; end
            9:  begin f.kind = 4'd7; f.op = 4'd2; f.imm = $urandom_range(32, 1000); end
            default: begin f.kind = 4'd6; f.op = 4'd10; f.imm = 32'd4096; end
        endcase
        return f;
    endfunction

    task automatic set_fields(fields_t f);
        bus.in_kind   = f.kind;
        bus.in_alu_op = f.op;
        bus.in_mem_f3 = f.f3;
        bus.in_rd     = f.rd;
        bus.in_rs1    = f.rs1;
        bus.in_rs2    = f.rs2;
        bus.in_imm    = f.imm;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_instr !== 32'h0 || bus.out_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: valid=%b instr=%h err=%b, required 0/00000000/0",
                     bus.out_valid, bus.out_instr, bus.out_err);
        end
        checks++;
        if (err_sticky !== 1'b0 || emit_cnt !== 16'd0 || err_cnt !== 16'd0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_status: sticky=%b emit=%0d err=%0d in_ready=%b, required 0/0/0/1",
                     err_sticky, emit_cnt, err_cnt, bus.in_ready);
        end
    endtask

    task automatic test_directed();
        fields_t     v [5];
        logic [31:0] ew [5] = '{32'h00500093, 32'h402081B3, 32'h00208463, 32'h123452B7, 32'h00000013};
        logic        ee [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        v[0] = '{kind: 4'd7, op: 4'd0,  f3: 3'd0, rd: 5'd1, rs1: 5'd0, rs2: 5'd0, imm: 32'd5};
        v[1] = '{kind: 4'd8, op: 4'd1,  f3: 3'd0, rd: 5'd3, rs1: 5'd1, rs2: 5'd2, imm: 32'd0};
        v[2] = '{kind: 4'd6, op: 4'd10, f3: 3'd0, rd: 5'd0, rs1: 5'd1, rs2: 5'd2, imm: 32'd8};
        v[3] = '{kind: 4'd0, op: 4'd0,  f3: 3'd0, rd: 5'd5, rs1: 5'd0, rs2: 5'd0, imm: 32'h12345000};
        v[4] = '{kind: 4'd0, op: 4'd0,  f3: 3'd0, rd: 5'd5, rs1: 5'd0, rs2: 5'd0, imm: 32'h12345001};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            set_fields(v[i]);
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.in_valid = 1'b0;
            #1;
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL latency_early[%0d]: out_valid=%b one edge after accept, required 0", i, bus.out_valid);
            end
            @(negedge clk);
            #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_instr !== ew[i] || bus.out_err !== ee[i]) begin
                errors++;
                $display("FAIL directed[%0d]: valid=%b instr=%h err=%b, required 1/%h/%b",
                         i, bus.out_valid, bus.out_instr, bus.out_err, ew[i], ee[i]);
            end
            checks++;
            if (err_sticky !== ee[i]) begin
                errors++;
                $display("FAIL sticky[%0d]: err_sticky=%b, required %b", i, err_sticky, ee[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        fields_t w [3];
        exp_t    e [3];
        int      k;
        bit      drop_valid;
        for (int i = 0; i < 3; i++) begin
            w[i] = rand_legal();
            e[i] = model(w[i]);
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        set_fields(w[0]);
        bus.in_valid = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_accept0: in_ready=%b, required 1", bus.in_ready);
        end
        @(negedge clk);
        set_fields(w[1]);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_accept1: in_ready=%b, required 1", bus.in_ready);
        end
        @(negedge clk);
        set_fields(w[2]);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_instr !== e[0].word) begin
            errors++;
            $display("FAIL bp_full: in_ready=%b out_valid=%b instr=%h, required 0/1/%h",
                     bus.in_ready, bus.out_valid, bus.out_instr, e[0].word);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_instr !== e[0].word) begin
            errors++;
            $display("FAIL bp_hold: in_ready=%b out_valid=%b instr=%h, required 0/1/%h",
                     bus.in_ready, bus.out_valid, bus.out_instr, e[0].word);
        end
        k = 0;
        drop_valid = 1'b0;
        for (int c = 0; c < 12 && k < 3; c++) begin
            @(negedge clk);
            if (drop_valid) bus.in_valid = 1'b0;
            bus.out_ready = 1'b1;
            #1;
            if (bus.in_valid && bus.in_ready) drop_valid = 1'b1;
            if (bus.out_valid) begin
                checks++;
                if (bus.out_instr !== e[k].word || bus.out_err !== e[k].err) begin
                    errors++;
                    $display("FAIL bp_order[%0d]: instr=%h err=%b, required %h/%b",
                             k, bus.out_instr, bus.out_err, e[k].word, e[k].err);
                end
                k++;
            end
        end
        checks++;
        if (k != 3) begin
            errors++;
            $display("FAIL bp_drain: got %0d words, required 3", k);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_stream();
        fields_t items [100];
        exp_t    expq [$];
        exp_t    e;
        int      bad_slot;
        int      idx;
        int      emitted;
        bit      accepted_last;
        do_reset();
        bad_slot = $urandom_range(0, 9);
        for (int i = 0; i < 100; i++) begin
            items[i] = (i % 10 == bad_slot) ? rand_illegal() : rand_legal();
        end
        idx = 0;
        emitted = 0;
        accepted_last = 1'b0;
        for (int c = 0; c < 2000 && emitted < 100; c++) begin
            @(negedge clk);
            if (!bus.in_valid || accepted_last) begin
                if (idx < 100) begin
                    set_fields(items[idx]);
                    bus.in_valid = ($urandom_range(0, 3) != 0);
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            bus.out_ready = $urandom_range(0, 1);
            #1;
            accepted_last = 1'b0;
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL stream_extra: unexpected word %h", bus.out_instr);
                end else begin
                    e = expq.pop_front();
                    if (bus.out_instr !== e.word || bus.out_err !== e.err) begin
                        errors++;
                        $display("FAIL stream_word[%0d]: instr=%h err=%b, required %h/%b",
                                 emitted, bus.out_instr, bus.out_err, e.word, e.err);
                    end
                end
                emitted++;
            end
            if (bus.in_valid && bus.in_ready) begin
                expq.push_back(model(items[idx]));
                idx++;
                accepted_last = 1'b1;
            end
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        checks++;
        if (emitted != 100) begin
            errors++;
            $display("FAIL stream_timeout: emitted %0d words, required 100", emitted);
        end
        checks++;
        if (emit_cnt !== 16'd100 || err_cnt !== 16'd10) begin
            errors++;
            $display("FAIL stream_counts: emit_cnt=%0d err_cnt=%0d, required 100/10", emit_cnt, err_cnt);
        end
        checks++;
        if (err_sticky !== 1'b1) begin
            errors++;
            $display("FAIL stream_sticky: err_sticky=%b, required 1", err_sticky);
        end
    endtask

    task automatic test_reset_midstream();
        fields_t w;
        @(negedge clk);
        bus.out_ready = 1'b0;
        w = rand_illegal();
        set_fields(w);
        bus.in_valid = 1'b1;
        @(negedge clk);
        w = rand_legal();
        set_fields(w);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_full: out_valid=%b in_ready=%b, required 1/0", bus.out_valid, bus.in_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_instr !== 32'h0 || emit_cnt !== 16'd0 ||
            err_cnt !== 16'd0 || err_sticky !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b instr=%h emit=%0d err=%0d sticky=%b, required 0/0/0/0/0",
                     bus.out_valid, bus.out_instr, emit_cnt, err_cnt, err_sticky);
        end
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (bus.out_valid !== 1'b0 || emit_cnt !== 16'd0) begin
                errors++;
                $display("FAIL mid_stale[%0d]: out_valid=%b emit_cnt=%0d, required 0/0",
                         c, bus.out_valid, emit_cnt);
            end
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_kind   = 4'd0;
        bus.in_alu_op = 4'd0;
        bus.in_mem_f3 = 3'd0;
        bus.in_rd     = 5'd0;
        bus.in_rs1    = 5'd0;
        bus.in_rs2    = 5'd0;
        bus.in_imm    = 32'd0;
        test_reset();
        test_directed();
        test_backpressure();
        test_stream();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
